// File: rtl/merge_pair_2to1_if.sv
// merge_pair_2to1_if
// Stream-side signals of the 2:1 run merger. The interface bundles the
// read ports of the two upstream first-word-fall-through FIFOs (A and B)
// and the write port of the downstream FIFO.
//   master : merger side (reads FIFO heads, drives pops and writes)
//   slave  : FIFO side (drives heads/flags, receives pops and writes)
// Signals:
//   i_a_dout/i_b_dout   head record of FIFO A/B, valid when not empty
//   i_a_empty/i_b_empty FIFO A/B empty
//   o_a_rd_en/o_b_rd_en pop FIFO A/B
//   o_out_din           record written downstream
//   o_out_wr_en         downstream write strobe
//   i_out_prog_full     downstream programmable-full
interface merge_pair_2to1_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] i_a_dout;
  logic                  i_a_empty;
  logic                  o_a_rd_en;
  logic [DATA_WIDTH-1:0] i_b_dout;
  logic                  i_b_empty;
  logic                  o_b_rd_en;
  logic [DATA_WIDTH-1:0] o_out_din;
  logic                  o_out_wr_en;
  logic                  i_out_prog_full;

  modport master (
    input  i_a_dout, i_a_empty,
    output o_a_rd_en,
    input  i_b_dout, i_b_empty,
    output o_b_rd_en,
    output o_out_din, o_out_wr_en,
    input  i_out_prog_full
  );

  modport slave (
    output i_a_dout, i_a_empty,
    input  o_a_rd_en,
    output i_b_dout, i_b_empty,
    input  o_b_rd_en,
    input  o_out_din, o_out_wr_en,
    output i_out_prog_full
  );
endinterface

// File: rtl/merge_pair_2to1.sv
// merge_pair_2to1
// Merges pairs of ascending-sorted runs (one run from FIFO A, one from
// FIFO B, each i_run_len records) into a single ascending run of twice the
// length written to a downstream FIFO. i_num_pairs run pairs are merged per
// i_start command. The sort key is the low KEY_WIDTH bits (unsigned); ties
// go to A so the merge is stable.
// Ports:
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   i_start      command pulse, honoured only when idle
//   i_run_len    records per run on each side, sampled with i_start
//   i_num_pairs  run pairs to merge, sampled with i_start
//   io_fifo      upstream FIFO read ports and downstream write port
//   o_busy       block is not idle
//   o_done       one-cycle pulse when all pairs are complete
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for i_start
// MERGE   | both runs pending; pop the smaller head when both present
// DRAIN_A | B run exhausted; pop the rest of the A run
// DRAIN_B | A run exhausted; pop the rest of the B run
// NEXT    | pair complete; reload counters or finish (no pops)
// DONE    | o_done pulse, then back to IDLE
module merge_pair_2to1 #(
  parameter int DATA_WIDTH    = 32,
  parameter int KEY_WIDTH     = 16,
  parameter int RUN_LEN_WIDTH = 16,
  parameter int PAIR_WIDTH    = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [RUN_LEN_WIDTH-1:0] i_run_len,
  input  logic [PAIR_WIDTH-1:0]    i_num_pairs,
  merge_pair_2to1_if.master        io_fifo,
  output logic                     o_busy,
  output logic                     o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MERGE,
    S_DRAIN_A,
    S_DRAIN_B,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [RUN_LEN_WIDTH-1:0] RL_ONE = RUN_LEN_WIDTH'(1);
  localparam logic [PAIR_WIDTH-1:0]    PR_ONE = PAIR_WIDTH'(1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [RUN_LEN_WIDTH-1:0] r_run_len;
  logic [RUN_LEN_WIDTH-1:0] r_rem_a;
  logic [RUN_LEN_WIDTH-1:0] r_rem_b;
  logic [PAIR_WIDTH-1:0]    r_pairs_left;
  logic [DATA_WIDTH-1:0]    r_out_din;
  logic                     r_out_wr_en;

  logic                 w_ok;
  logic                 w_a_vld;
  logic                 w_b_vld;
  logic [KEY_WIDTH-1:0] w_key_a;
  logic [KEY_WIDTH-1:0] w_key_b;
  logic                 w_a_first;
  logic                 w_cmd_empty;
  logic                 w_pop_a;
  logic                 w_pop_b;

  assign w_ok        = !io_fifo.i_out_prog_full;
  assign w_a_vld     = !io_fifo.i_a_empty;
  assign w_b_vld     = !io_fifo.i_b_empty;
  assign w_key_a     = io_fifo.i_a_dout[KEY_WIDTH-1:0];
  assign w_key_b     = io_fifo.i_b_dout[KEY_WIDTH-1:0];
  assign w_a_first   = (w_key_a <= w_key_b);
  assign w_cmd_empty = (i_run_len == '0) || (i_num_pairs == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // In MERGE nothing pops unless both heads are present: popping the only
  // available side could emit a record larger than one still to arrive.
  always_comb begin
    w_state_nxt = r_state;
    w_pop_a     = 1'b0;
    w_pop_b     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = w_cmd_empty ? S_DONE : S_MERGE;
        end
      end
      S_MERGE: begin
        if (w_a_vld && w_b_vld && w_ok) begin
          if (w_a_first) begin
            w_pop_a = 1'b1;
            if (r_rem_a == RL_ONE) w_state_nxt = S_DRAIN_B;
          end else begin
            w_pop_b = 1'b1;
            if (r_rem_b == RL_ONE) w_state_nxt = S_DRAIN_A;
          end
        end
      end
      S_DRAIN_A: begin
        if (w_a_vld && w_ok) begin
          w_pop_a = 1'b1;
          if (r_rem_a == RL_ONE) w_state_nxt = S_NEXT;
        end
      end
      S_DRAIN_B: begin
        if (w_b_vld && w_ok) begin
          w_pop_b = 1'b1;
          if (r_rem_b == RL_ONE) w_state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        w_state_nxt = (r_pairs_left == PR_ONE) ? S_DONE : S_MERGE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Run/pair bookkeeping. The run length is kept so each new pair can
  // reload both remaining-record counters from NEXT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_run_len    <= '0;
      r_rem_a      <= '0;
      r_rem_b      <= '0;
      r_pairs_left <= '0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_run_len    <= i_run_len;
      r_rem_a      <= i_run_len;
      r_rem_b      <= i_run_len;
      r_pairs_left <= i_num_pairs;
    end else if ((r_state == S_NEXT) && (r_pairs_left != PR_ONE)) begin
      r_rem_a      <= r_run_len;
      r_rem_b      <= r_run_len;
      r_pairs_left <= r_pairs_left - PR_ONE;
    end else begin
      if (w_pop_a) r_rem_a <= r_rem_a - RL_ONE;
      if (w_pop_b) r_rem_b <= r_rem_b - RL_ONE;
    end
  end

  // One-stage output register: the popped head is written downstream on
  // the following clock; the data register holds when nothing is written.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_wr_en <= 1'b0;
      r_out_din   <= '0;
    end else begin
      r_out_wr_en <= w_pop_a || w_pop_b;
      if (w_pop_a) begin
        r_out_din <= io_fifo.i_a_dout;
      end else if (w_pop_b) begin
        r_out_din <= io_fifo.i_b_dout;
      end
    end
  end

  assign io_fifo.o_a_rd_en   = w_pop_a;
  assign io_fifo.o_b_rd_en   = w_pop_b;
  assign io_fifo.o_out_din   = r_out_din;
  assign io_fifo.o_out_wr_en = r_out_wr_en;
  assign o_busy              = (r_state != S_IDLE);
  assign o_done              = (r_state == S_DONE);

endmodule

// File: tb/tb_merge_pair_2to1.sv
// Directed bench for merge_pair_2to1. Upstream FIFOs are modelled as
// arrays with read pointers presenting a fall-through head; the downstream
// FIFO is a write monitor. Bench inputs change on the falling edge and all
// checks sample 1 time unit after the rising edge.
module tb_merge_pair_2to1;
  localparam int DW = 32;
  localparam int KW = 16;
  localparam int RW = 16;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [RW-1:0] run_len;
  logic [PW-1:0] num_pairs;
  logic          busy;
  logic          done;

  merge_pair_2to1_if #(.DATA_WIDTH(DW)) fifo_if ();

  merge_pair_2to1 #(
    .DATA_WIDTH(DW), .KEY_WIDTH(KW), .RUN_LEN_WIDTH(RW), .PAIR_WIDTH(PW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_run_len(run_len),
    .i_num_pairs(num_pairs), .io_fifo(fifo_if), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Upstream FIFO model: main process owns contents/write pointer/floor,
  // the falling-edge process owns the read pointer.
  logic [DW-1:0] mem_a [64];
  logic [DW-1:0] mem_b [64];
  int wa = 0, wb = 0, floor_a = 0, floor_b = 0;
  int ra = 0, rb = 0;
  logic stall_b = 1'b0;
  logic pfull = 1'b0;

  logic pop_a_q = 1'b0, pop_b_q = 1'b0;
  int a_pops = 0, b_pops = 0, viol_excl = 0, viol_pf = 0;
  int rd_seq [$];
  logic [DW-1:0] wr_data [$];
  int wr_cyc [$];
  int done_cnt = 0;

  logic [DW-1:0] exp_q [$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    pop_a_q = fifo_if.o_a_rd_en;
    pop_b_q = fifo_if.o_b_rd_en;
    if (pop_a_q && pop_b_q) viol_excl++;
    if ((pop_a_q || pop_b_q) && fifo_if.i_out_prog_full) viol_pf++;
    if (pop_a_q) begin a_pops++; rd_seq.push_back(0); end
    if (pop_b_q) begin b_pops++; rd_seq.push_back(1); end
  end

  always @(negedge clk) begin
    if (fifo_if.o_out_wr_en === 1'b1) begin
      wr_data.push_back(fifo_if.o_out_din);
      wr_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cnt++;
    if (pop_a_q && ra < wa) ra++;
    if (pop_b_q && rb < wb) rb++;
    if (ra < floor_a) ra = floor_a;
    if (rb < floor_b) rb = floor_b;
    fifo_if.i_a_dout        = (ra < wa) ? mem_a[ra] : '0;
    fifo_if.i_a_empty       = !(ra < wa);
    fifo_if.i_b_dout        = (rb < wb) ? mem_b[rb] : '0;
    fifo_if.i_b_empty       = stall_b || !(rb < wb);
    fifo_if.i_out_prog_full = pfull;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [DW-1:0] d);
    mem_a[wa] = d;
    wa++;
  endtask

  task automatic push_b(input logic [DW-1:0] d);
    mem_b[wb] = d;
    wb++;
  endtask

  task automatic load_basic();
    push_a(1); push_a(3); push_a(5); push_a(7);
    push_b(2); push_b(4); push_b(6); push_b(8);
    exp_q = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
  endtask

  task automatic kick(input int rl, input int np, output int sc);
    run_len   = RW'(rl);
    num_pairs = PW'(np);
    start     = 1'b1;
    sc        = cyc;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int done_at);
    int i = 0;
    while (i < budget && done !== 1'b1) begin
      step();
      i++;
    end
    chk({tag, "_done"}, 32'(done), 1);
    done_at = cyc;
    chk({tag, "_busy_in_done"}, 32'(busy), 1);
    step();
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  task automatic check_writes(input string tag, input int base);
    chk({tag, "_count"}, wr_data.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < wr_data.size()) chk(tag, wr_data[base+i], exp_q[i]);
    end
  endtask

  initial begin
    int sc, da, wbase, rbase, dbase, pa, pb, vp, pk, n;
    rst = 1'b1; start = 1'b0; run_len = '0; num_pairs = '0;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr_en", 32'(fifo_if.o_out_wr_en), 0);
    chk("rst_din", fifo_if.o_out_din, 0);
    chk("rst_a_rd_en", 32'(fifo_if.o_a_rd_en), 0);
    chk("rst_b_rd_en", 32'(fifo_if.o_b_rd_en), 0);
    rst = 1'b0;
    step();

    // Basic merge
    load_basic();
    wbase = wr_data.size(); dbase = done_cnt;
    kick(4, 1, sc);
    wait_done("basic", 40, da);
    check_writes("basic_data", wbase);
    chk("basic_latency", wr_cyc[wbase], sc + 2);
    chk("basic_consecutive", wr_cyc[wbase+7] - wr_cyc[wbase], 7);
    chk("basic_done_timing", da, wr_cyc[wbase+7] + 1);
    chk("basic_done_count", done_cnt - dbase, 1);

    // Tie goes to A
    push_a(32'h0001_0005); push_b(32'h0002_0005);
    exp_q = {32'h0001_0005, 32'h0002_0005};
    wbase = wr_data.size(); rbase = rd_seq.size();
    kick(1, 1, sc);
    wait_done("tie", 20, da);
    check_writes("tie_data", wbase);
    chk("tie_first_pop_a", rd_seq[rbase], 0);

    // All of B below A: A must not pop until B is exhausted
    push_a(10); push_a(11); push_a(12);
    push_b(1); push_b(2); push_b(3);
    exp_q = {32'd1, 32'd2, 32'd3, 32'd10, 32'd11, 32'd12};
    wbase = wr_data.size(); rbase = rd_seq.size();
    kick(3, 1, sc);
    wait_done("drain", 30, da);
    check_writes("drain_data", wbase);
    for (int i = 0; i < 6; i++) chk("drain_pop_order", rd_seq[rbase+i], (i < 3) ? 1 : 0);

    // Two pairs, with a stray start mid-run that must be ignored
    push_a(3); push_a(9); push_a(1); push_a(2);
    push_b(4); push_b(5); push_b(0); push_b(7);
    exp_q = {32'd3, 32'd4, 32'd5, 32'd9, 32'd0, 32'd1, 32'd2, 32'd7};
    wbase = wr_data.size(); dbase = done_cnt;
    kick(2, 2, sc);
    step();
    run_len = 16'd7; num_pairs = 16'd5; start = 1'b1;
    step();
    start = 1'b0;
    wait_done("multi", 40, da);
    check_writes("multi_data", wbase);
    chk("multi_first_run_span", wr_cyc[wbase+3] - wr_cyc[wbase], 3);
    chk("multi_next_gap", wr_cyc[wbase+4] - wr_cyc[wbase+3], 2);
    chk("multi_done_count", done_cnt - dbase, 1);
    chk("multi_done_timing", da, wr_cyc[wbase+7] + 1);

    // Downstream backpressure for 5 cycles
    load_basic();
    wbase = wr_data.size(); vp = viol_pf;
    kick(4, 1, sc);
    step(); step();
    pfull = 1'b1; pk = cyc; pa = a_pops + b_pops;
    repeat (5) step();
    chk("bp_no_pops", a_pops + b_pops - pa, 0);
    pfull = 1'b0;
    wait_done("bp", 40, da);
    check_writes("bp_data", wbase);
    chk("bp_rd_en_while_full", viol_pf - vp, 0);
    n = 0;
    for (int i = wbase; i < wr_data.size(); i++) if (wr_cyc[i] > pk && wr_cyc[i] <= pk + 5) n++;
    chk("bp_writes_after_rise_le1", 32'(n <= 1), 1);

    // B head missing for 3 cycles: A must not pop either
    load_basic();
    wbase = wr_data.size();
    kick(4, 1, sc);
    step();
    stall_b = 1'b1; pa = a_pops; pb = b_pops;
    repeat (3) step();
    chk("stall_no_a_pop", a_pops - pa, 0);
    chk("stall_no_b_pop", b_pops - pb, 0);
    stall_b = 1'b0;
    wait_done("stall", 40, da);
    check_writes("stall_data", wbase);

    // Zero run length / zero pairs: straight to DONE, nothing moves
    push_a(99); push_b(98);
    wbase = wr_data.size(); pa = a_pops + b_pops;
    kick(0, 3, sc);
    wait_done("zero_len", 1, da);
    chk("zero_len_done_next", da, sc + 1);
    kick(3, 0, sc);
    wait_done("zero_pairs", 1, da);
    chk("zero_pairs_done_next", da, sc + 1);
    step();
    chk("zero_no_pops", a_pops + b_pops - pa, 0);
    chk("zero_no_writes", wr_data.size() - wbase, 0);
    floor_a = wa; floor_b = wb;
    step();

    // Reset during MERGE, then a fresh merge
    load_basic();
    kick(4, 1, sc);
    step(); step();
    chk("mid_wr_active", 32'(fifo_if.o_out_wr_en), 1);
    rst = 1'b1;
    step();
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_wr_en", 32'(fifo_if.o_out_wr_en), 0);
    chk("mrst_din", fifo_if.o_out_din, 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_a_rd_en", 32'(fifo_if.o_a_rd_en), 0);
    chk("mrst_b_rd_en", 32'(fifo_if.o_b_rd_en), 0);
    rst = 1'b0;
    floor_a = wa; floor_b = wb;
    step();
    push_a(20); push_a(21); push_b(5); push_b(30);
    exp_q = {32'd5, 32'd20, 32'd21, 32'd30};
    wbase = wr_data.size();
    kick(2, 1, sc);
    wait_done("restart", 30, da);
    check_writes("restart_data", wbase);

    chk("rd_en_exclusive", viol_excl, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
